// File: rtl/hazard3_instr_aligner_pkg.sv
// Shared definitions for the Hazard3 instruction aligner: halfword width,
// instruction-length test, consumed-halfword encoding and a modular add
// helper for circular pointers whose modulus need not be a power of two.
package hazard3_instr_aligner_pkg;

    localparam int HW_W = 16;

    // Number of halfwords consumed from the window in one cycle.
    typedef enum logic [1:0] {
        USED_NONE = 2'd0,
        USED_ONE  = 2'd1,
        USED_TWO  = 2'd2
    } used_t;

    // A halfword whose two low bits are 2'b11 starts a 32-bit instruction.
    function automatic logic is_32bit_op(input logic [HW_W-1:0] hw);
        return hw[1:0] == 2'b11;
    endfunction

    // (a + b) mod depth, valid while a + b < 2 * depth.
    function automatic int unsigned wrap_add(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned depth);
        int unsigned s;
        s = a + b;
        return (s >= depth) ? s - depth : s;
    endfunction

endpackage

// File: rtl/hazard3_hw_buf.sv
// Circular halfword storage for the instruction aligner. Owns the read
// pointer; the write position is given as an offset from it (the current
// fill count). Two-wide write port, two-lane read window at the read
// pointer, synchronous clear.
module hazard3_hw_buf
    import hazard3_instr_aligner_pkg::*;
#(
    parameter int DEPTH_HW = 6,
    parameter int W_CNT    = $clog2(DEPTH_HW + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic [1:0]        adv_i,
    input  logic [W_CNT-1:0]  wr_base_i,
    input  logic [1:0]        wr_en_i,
    input  logic [2*HW_W-1:0] wr_data_i,
    output logic [2*HW_W-1:0] rd_data_o
);

    localparam int PTR_W = $clog2(DEPTH_HW);

    logic [PTR_W-1:0] rd_q;
    logic [PTR_W-1:0] rd_d;
    logic [PTR_W-1:0] rd_p1;
    logic [PTR_W-1:0] wr_p0;
    logic [PTR_W-1:0] wr_p1;
    logic [HW_W-1:0]  mem_q [DEPTH_HW];

    // Pointer arithmetic, all modulo DEPTH_HW.
    always_comb begin
        rd_p1 = PTR_W'(wrap_add(32'(rd_q), 32'd1, DEPTH_HW));
        wr_p0 = PTR_W'(wrap_add(32'(rd_q), 32'(wr_base_i), DEPTH_HW));
        wr_p1 = PTR_W'(wrap_add(32'(wr_p0), 32'd1, DEPTH_HW));
        rd_d  = clr_i ? '0 : PTR_W'(wrap_add(32'(rd_q), 32'(adv_i), DEPTH_HW));
    end

    // Read pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    // Halfword storage; contents need no reset since the count masks them.
    always_ff @(posedge clk) begin
        if (wr_en_i[0]) begin
            mem_q[wr_p0] <= wr_data_i[HW_W-1:0];
        end
        if (wr_en_i[1]) begin
            mem_q[wr_p1] <= wr_data_i[2*HW_W-1:HW_W];
        end
    end

    assign rd_data_o = {mem_q[rd_p1], mem_q[rd_q]};

endmodule

// File: rtl/hazard3_instr_aligner.sv
// Hazard3 instruction aligner: buffers 32-bit fetch words as halfwords and
// presents a 32-bit window starting at the current instruction boundary.
// Optional feature macro: HAZARD3_ALIGNER_FWD_EN -- forwards a word being
// pushed into empty window lanes in the same cycle (zero-latency path).
module hazard3_instr_aligner
    import hazard3_instr_aligner_pkg::*;
#(
    parameter int DEPTH_HW = 6,
    parameter int W_CNT    = $clog2(DEPTH_HW + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_valid,
    input  logic [31:0]      fetch_data,
    output logic             fetch_ready,
    input  logic             jump_valid,
    input  logic             jump_target_hw,
    output logic [31:0]      cir,
    output logic [1:0]       cir_vld,
    output logic             cir_ready,
    input  logic             cir_advance,
    input  logic             cir_is_32bit,
    output logic [W_CNT-1:0] level
);

    // Handshake: a fetch word transfers when fetch_valid && fetch_ready;
    // fetch_ready depends on registered count only. The decompressor
    // consumes with cir_advance, legal only when cir holds enough halfwords.

    logic [W_CNT-1:0]  count_q, count_d;
    logic              discard_lo_q, discard_lo_d;
    logic              push;
    logic [1:0]        push_n;
    logic [HW_W-1:0]   push_hw0, push_hw1;
    used_t             used_raw, used;
    logic [1:0]        wr_en;
    logic [W_CNT:0]    pos0, pos1;
    logic [2*HW_W-1:0] stored;
    logic [HW_W-1:0]   lane0, lane1;
    logic              lane0_vld, lane1_vld;

    assign fetch_ready = (count_q <= W_CNT'(DEPTH_HW - 2));
    assign level       = count_q;

    // Push decode, consumption amount and buffer write enables.
    always_comb begin
        push     = fetch_valid && fetch_ready && !jump_valid && !rst;
        push_hw0 = discard_lo_q ? fetch_data[31:16] : fetch_data[15:0];
        push_hw1 = fetch_data[31:16];
        if (!push) begin
            push_n = 2'd0;
        end else if (discard_lo_q) begin
            push_n = 2'd1;
        end else begin
            push_n = 2'd2;
        end
        used_raw = cir_advance ? (cir_is_32bit ? USED_TWO : USED_ONE) : USED_NONE;
        used     = jump_valid ? USED_NONE : used_raw;
        // Pushed halfword j sits at logical position count+j; anything
        // below the consumed amount was taken straight from the forward
        // path and is not stored.
        pos0     = {1'b0, count_q};
        pos1     = pos0 + (W_CNT+1)'(1);
        wr_en[0] = (push_n >= 2'd1) && (pos0 >= (W_CNT+1)'(used));
        wr_en[1] = (push_n >= 2'd2) && (pos1 >= (W_CNT+1)'(used));
    end

    // Window lanes from storage, optionally topped up by the incoming word.
    always_comb begin
        lane0     = stored[HW_W-1:0];
        lane1     = stored[2*HW_W-1:HW_W];
        lane0_vld = (count_q >= W_CNT'(1));
        lane1_vld = (count_q >= W_CNT'(2));
`ifdef HAZARD3_ALIGNER_FWD_EN
        if (count_q == W_CNT'(0)) begin
            lane0     = push_hw0;
            lane0_vld = (push_n >= 2'd1);
            lane1     = push_hw1;
            lane1_vld = (push_n >= 2'd2);
        end else if (count_q == W_CNT'(1)) begin
            lane1     = push_hw0;
            lane1_vld = (push_n >= 2'd1);
        end
`endif
        cir       = {lane1_vld ? lane1 : {HW_W{1'b0}},
                     lane0_vld ? lane0 : {HW_W{1'b0}}};
        cir_vld   = lane1_vld ? 2'd2 : (lane0_vld ? 2'd1 : 2'd0);
        cir_ready = lane0_vld && (!is_32bit_op(cir[HW_W-1:0]) || lane1_vld);
    end

    // Next fill count and misaligned-jump discard flag.
    always_comb begin
        count_d      = count_q;
        discard_lo_d = discard_lo_q;
        if (jump_valid) begin
            count_d      = '0;
            discard_lo_d = jump_target_hw;
        end else begin
            count_d = count_q - W_CNT'(used) + W_CNT'(push_n);
            if (push) begin
                discard_lo_d = 1'b0;
            end
        end
    end

    // Count and discard registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            discard_lo_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            discard_lo_q <= discard_lo_d;
        end
    end

    hazard3_hw_buf #(
        .DEPTH_HW (DEPTH_HW),
        .W_CNT    (W_CNT)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (jump_valid),
        .adv_i     (used),
        .wr_base_i (count_q),
        .wr_en_i   (wr_en),
        .wr_data_i ({push_hw1, push_hw0}),
        .rd_data_o (stored)
    );

    // Consuming more halfwords than the window holds is illegal.
    always_ff @(posedge clk) begin
        if (!rst && !jump_valid && cir_advance) begin
            assert (2'(used_raw) <= cir_vld);
        end
    end

endmodule

// File: tb/tb_hazard3_instr_aligner.sv
// Self-checking bench for hazard3_instr_aligner (default build, no forwarding).
module tb_hazard3_instr_aligner;

    localparam int DEPTH_HW = 6;
    localparam int W_CNT    = $clog2(DEPTH_HW + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             fetch_valid = 1'b0;
    logic [31:0]      fetch_data = '0;
    logic             fetch_ready;
    logic             jump_valid = 1'b0;
    logic             jump_target_hw = 1'b0;
    logic [31:0]      cir;
    logic [1:0]       cir_vld;
    logic             cir_ready;
    logic             cir_advance = 1'b0;
    logic             cir_is_32bit = 1'b0;
    logic [W_CNT-1:0] level;

    int checks = 0;
    int passes = 0;

    // Reference model: ordered halfword stream plus pending low-half discard.
    logic [15:0] mq[$];
    bit          m_disc = 1'b0;

    hazard3_instr_aligner #(.DEPTH_HW(DEPTH_HW)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_valid    (fetch_valid),
        .fetch_data     (fetch_data),
        .fetch_ready    (fetch_ready),
        .jump_valid     (jump_valid),
        .jump_target_hw (jump_target_hw),
        .cir            (cir),
        .cir_vld        (cir_vld),
        .cir_ready      (cir_ready),
        .cir_advance    (cir_advance),
        .cir_is_32bit   (cir_is_32bit),
        .level          (level)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [31:0] m_cir();
        logic [15:0] l0, l1;
        l0 = (mq.size() > 0) ? mq[0] : 16'h0;
        l1 = (mq.size() > 1) ? mq[1] : 16'h0;
        return {l1, l0};
    endfunction

    function automatic logic [1:0] m_vld();
        return (mq.size() >= 2) ? 2'd2 : 2'(mq.size());
    endfunction

    function automatic logic m_ready();
        logic [31:0] c;
        c = m_cir();
        if (mq.size() == 0) return 1'b0;
        if (c[1:0] == 2'b11) return mq.size() >= 2;
        return 1'b1;
    endfunction

    function automatic logic m_fready();
        return mq.size() <= DEPTH_HW - 2;
    endfunction

    // Driver: apply one cycle of inputs, step the model at the clock edge,
    // return 1 time unit after the edge so outputs can be sampled.
    task automatic drive(input logic fv, input logic [31:0] fd, input logic jv,
                         input logic jt, input logic adv, input logic is32,
                         input logic r);
        bit fr;
        fetch_valid    = fv;
        fetch_data     = fd;
        jump_valid     = jv;
        jump_target_hw = jt;
        cir_advance    = adv;
        cir_is_32bit   = is32;
        rst            = r;
        fr = m_fready();
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_disc = 1'b0;
        end else if (jv) begin
            mq.delete();
            m_disc = jt;
        end else begin
            if (adv) begin
                void'(mq.pop_front());
                if (is32) void'(mq.pop_front());
            end
            if (fv && fr) begin
                if (!m_disc) mq.push_back(fd[15:0]);
                mq.push_back(fd[31:16]);
                m_disc = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        drive(1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (level !== '0) $display("FAIL reset_level: got %0d want 0", level); else passes++;
        checks++; if (fetch_ready !== 1'b1) $display("FAIL reset_fetch_ready: got %b want 1", fetch_ready); else passes++;
        checks++; if (cir !== 32'h0) $display("FAIL reset_cir: got %h want 0", cir); else passes++;
        checks++; if (cir_vld !== 2'd0) $display("FAIL reset_cir_vld: got %0d want 0", cir_vld); else passes++;
        checks++; if (cir_ready !== 1'b0) $display("FAIL reset_cir_ready: got %b want 0", cir_ready); else passes++;
        idle();
    endtask

    task automatic test_aligned();
        checks++; if (cir_ready !== 1'b0) $display("FAIL aligned_pre_ready: got %b want 0", cir_ready); else passes++;
        drive(1'b1, 32'h00000013, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (cir_ready !== 1'b1) $display("FAIL aligned_latency_ready: got %b want 1", cir_ready); else passes++;
        checks++; if (cir !== 32'h00000013) $display("FAIL aligned_cir0: got %h want 00000013", cir); else passes++;
        checks++; if (cir_vld !== 2'd2) $display("FAIL aligned_vld0: got %0d want 2", cir_vld); else passes++;
        drive(1'b1, 32'h00100093, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (cir !== 32'h00100093) $display("FAIL aligned_cir1: got %h want 00100093", cir); else passes++;
        checks++; if (cir_vld !== 2'd2) $display("FAIL aligned_vld1: got %0d want 2", cir_vld); else passes++;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (cir_vld !== 2'd0) $display("FAIL aligned_empty_vld: got %0d want 0", cir_vld); else passes++;
        checks++; if (cir_ready !== 1'b0) $display("FAIL aligned_empty_ready: got %b want 0", cir_ready); else passes++;
    endtask

    task automatic test_mixed();
        drive(1'b1, 32'h00134581, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (cir[15:0] !== 16'h4581) $display("FAIL mixed_c_li: got %h want 4581", cir[15:0]); else passes++;
        drive(1'b1, 32'hABCD0013, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (cir !== 32'h00130013) $display("FAIL mixed_straddle: got %h want 00130013", cir); else passes++;
        checks++; if (level !== W_CNT'(3)) $display("FAIL mixed_level: got %0d want 3", level); else passes++;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (cir !== 32'h0000ABCD) $display("FAIL mixed_tail_cir: got %h want 0000abcd", cir); else passes++;
        checks++; if (cir_vld !== 2'd1) $display("FAIL mixed_tail_vld: got %0d want 1", cir_vld); else passes++;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_misaligned_jump();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (cir_vld !== 2'd0) $display("FAIL mjump_vld_after_jump: got %0d want 0", cir_vld); else passes++;
        drive(1'b1, 32'h11112222, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (level !== W_CNT'(1)) $display("FAIL mjump_level: got %0d want 1", level); else passes++;
        checks++; if (cir !== 32'h00001111) $display("FAIL mjump_cir: got %h want 00001111", cir); else passes++;
        checks++; if (cir_ready !== 1'b1) $display("FAIL mjump_ready: got %b want 1", cir_ready); else passes++;
        drive(1'b1, 32'h33334444, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (cir !== 32'h33334444) $display("FAIL mjump_discard_cleared: got %h want 33334444", cir); else passes++;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_full();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) drive(1'b1, 32'h55555555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (level !== W_CNT'(5)) $display("FAIL full_level5: got %0d want 5", level); else passes++;
        checks++; if (fetch_ready !== 1'b0) $display("FAIL full_not_ready: got %b want 0", fetch_ready); else passes++;
        drive(1'b1, 32'h66666666, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (level !== W_CNT'(4)) $display("FAIL full_level4: got %0d want 4", level); else passes++;
        checks++; if (fetch_ready !== 1'b1) $display("FAIL full_ready_again: got %b want 1", fetch_ready); else passes++;
        drive(1'b1, 32'h66666666, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (level !== W_CNT'(6)) $display("FAIL full_level6: got %0d want 6", level); else passes++;
        checks++; if (fetch_ready !== 1'b0) $display("FAIL full_level6_ready: got %b want 0", fetch_ready); else passes++;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 32'h00000013, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (level !== W_CNT'(2)) $display("FAIL simul_pre_level: got %0d want 2", level); else passes++;
        drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (level !== '0) $display("FAIL simul_level: got %0d want 0", level); else passes++;
        checks++; if (cir_vld !== 2'd0) $display("FAIL simul_vld: got %0d want 0", cir_vld); else passes++;
        checks++; if (cir !== 32'h0) $display("FAIL simul_cir: got %h want 0", cir); else passes++;
        idle();
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h0001A001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h0002B002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (level !== W_CNT'(3)) $display("FAIL rmid_pre_level: got %0d want 3", level); else passes++;
        drive(1'b1, 32'h0003C003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (level !== '0) $display("FAIL rmid_level: got %0d want 0", level); else passes++;
        checks++; if (fetch_ready !== 1'b1) $display("FAIL rmid_fetch_ready: got %b want 1", fetch_ready); else passes++;
        checks++; if (cir !== 32'h0) $display("FAIL rmid_cir: got %h want 0", cir); else passes++;
        idle();
    endtask

    task automatic test_random();
        logic        fv, jv, jt, adv, is32, r;
        logic [31:0] fd, ec;
        for (int i = 0; i < 600; i++) begin
            ec   = m_cir();
            fv   = ($urandom_range(0, 3) != 0);
            fd   = $urandom;
            jv   = ($urandom_range(0, 19) == 0);
            jt   = $urandom_range(0, 1);
            r    = ($urandom_range(0, 99) == 0);
            adv  = m_ready() && ($urandom_range(0, 2) != 0);
            is32 = adv && (ec[1:0] == 2'b11);
            drive(fv, fd, jv, jt, adv, is32, r);
            checks++; if (cir !== m_cir()) $display("FAIL rand_cir[%0d]: got %h want %h", i, cir, m_cir()); else passes++;
            checks++; if (cir_vld !== m_vld()) $display("FAIL rand_vld[%0d]: got %0d want %0d", i, cir_vld, m_vld()); else passes++;
            checks++; if (cir_ready !== m_ready()) $display("FAIL rand_ready[%0d]: got %b want %b", i, cir_ready, m_ready()); else passes++;
            checks++; if (fetch_ready !== m_fready()) $display("FAIL rand_fetch_ready[%0d]: got %b want %b", i, fetch_ready, m_fready()); else passes++;
            checks++; if (level !== W_CNT'(mq.size())) $display("FAIL rand_level[%0d]: got %0d want %0d", i, level, mq.size()); else passes++;
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_mixed();
        test_misaligned_jump();
        test_full();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
